// File: rtl/spdif_subframe_decoder_if.sv
// Line-side inputs and decoded-result outputs of the S/PDIF sub-frame decoder.
// master = preamble detector / testbench side, slave = decoder side.
interface spdif_subframe_decoder_if;
  logic        i_spdif;
  logic        i_enable;
  logic [2:0]  i_flag;
  logic        o_valid;
  logic [23:0] o_sample;
  logic        o_channel;
  logic        o_block_start;
  logic [2:0]  o_status;
  logic        o_parity_err;
  logic        o_frame_err;
  logic [31:0] o_cstat;
  logic        o_cstat_valid;

  modport master (
    output i_spdif, i_enable, i_flag,
    input  o_valid, o_sample, o_channel, o_block_start, o_status,
           o_parity_err, o_frame_err, o_cstat, o_cstat_valid
  );

  modport slave (
    input  i_spdif, i_enable, i_flag,
    output o_valid, o_sample, o_channel, o_block_start, o_status,
           o_parity_err, o_frame_err, o_cstat, o_cstat_valid
  );
endinterface

// File: rtl/spdif_subframe_decoder.sv
// Biphase-mark decoder for the 28 data timeslots of an S/PDIF sub-frame; optional SPDIF_CSTAT_EN collects channel status.
// Latency: o_valid 168 cycles after the enable-rise cycle, fields registered and held until the next o_valid.
// Backpressure: none; o_valid / o_frame_err / o_cstat_valid are single-cycle pulses that must be accepted.
module spdif_subframe_decoder #(
  parameter int SPS   = 6,
  parameter int SLOTS = 28
) (
  input logic                     clk,
  input logic                     i_rst,
  spdif_subframe_decoder_if.slave bus
);

  localparam int              PW       = $clog2(SPS);
  localparam logic [7:0]      LAST_IDX = 8'(SPS * SLOTS - 1);
  localparam logic [PW-1:0]   PH_LAST  = PW'(SPS - 1);
  localparam logic [PW-1:0]   PH_A     = PW'(1);
  localparam logic [PW-1:0]   PH_B     = PW'(SPS / 2 + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start;
  logic             w_take_last;
  logic             w_abort;
  logic             w_flag_legal;
  logic             w_is_y;
  logic             w_is_z;

  logic             r_armed;
  logic [2:0]       r_flag;
  logic [7:0]       r_idx;
  logic [PW-1:0]    r_phase;
  logic             r_s1;
  logic [SLOTS-1:0] r_shift;

  logic             r_valid;
  logic             r_frame_err;
  logic [23:0]      r_sample;
  logic             r_channel;
  logic             r_block_start;
  logic [2:0]       r_status;
  logic             r_parity_err;

  assign w_flag_legal = (bus.i_flag != 3'b000) && (bus.i_flag != 3'b111);
  assign w_is_y       = (r_flag == 3'b010) || (r_flag == 3'b101);
  assign w_is_z       = (r_flag == 3'b100) || (r_flag == 3'b011);

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Index 167 is the last phase of slot 27, so the shift register is already complete when it is taken.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_take_last = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_enable && r_armed && w_flag_legal) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end
      end
      S_RUN: begin
        if (!bus.i_enable) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
          w_take_last = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A new sub-frame needs a fresh enable rise; the detector's hand-off overlap must not restart us.
  always_ff @(posedge clk) begin
    if (i_rst)                     r_armed <= 1'b0;
    else if (!bus.i_enable)        r_armed <= 1'b1;
    else if (r_state == S_IDLE)    r_armed <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_flag  <= 3'b000;
      r_idx   <= 8'd0;
      r_phase <= '0;
      r_s1    <= 1'b0;
      r_shift <= '0;
    end else if (w_start) begin
      r_flag  <= bus.i_flag;
      r_idx   <= 8'd1;
      r_phase <= PH_A;
    end else if (r_state == S_RUN && bus.i_enable) begin
      r_idx   <= r_idx + 8'd1;
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
      if (r_phase == PH_A) r_s1 <= bus.i_spdif;
      if (r_phase == PH_B) r_shift <= {r_s1 ^ bus.i_spdif, r_shift[SLOTS-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_sample      <= '0;
      r_channel     <= 1'b0;
      r_block_start <= 1'b0;
      r_status      <= 3'b000;
      r_parity_err  <= 1'b0;
    end else begin
      r_valid     <= w_take_last;
      r_frame_err <= w_abort;
      if (w_take_last) begin
        r_sample      <= r_shift[23:0];
        r_channel     <= w_is_y;
        r_block_start <= w_is_z;
        r_status      <= {r_shift[24], r_shift[25], r_shift[26]};
        r_parity_err  <= ^r_shift;
      end
    end
  end

  assign bus.o_valid       = r_valid;
  assign bus.o_frame_err   = r_frame_err;
  assign bus.o_sample      = r_sample;
  assign bus.o_channel     = r_channel;
  assign bus.o_block_start = r_block_start;
  assign bus.o_status      = r_status;
  assign bus.o_parity_err  = r_parity_err;

`ifdef SPDIF_CSTAT_EN
  logic [7:0]  r_fcnt;
  logic        r_collect;
  logic [31:0] r_cstat_acc;
  logic [31:0] r_cstat;
  logic        r_cstat_valid;
  logic [7:0]  w_fidx;
  logic        w_fcollect;
  logic        w_left_done;

  // A Z left sub-frame is frame 0 of the block and (re)opens collection.
  always_comb begin
    w_fidx      = w_is_z ? 8'd0 : r_fcnt;
    w_fcollect  = w_is_z || r_collect;
    w_left_done = w_take_last && !w_is_y;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_fcnt        <= 8'd0;
      r_collect     <= 1'b0;
      r_cstat_acc   <= '0;
      r_cstat       <= '0;
      r_cstat_valid <= 1'b0;
    end else begin
      r_cstat_valid <= 1'b0;
      if (w_abort) begin
        r_collect <= 1'b0;
      end else if (w_left_done) begin
        r_fcnt    <= (w_fidx == 8'd191) ? 8'd191 : w_fidx + 8'd1;
        r_collect <= w_fcollect;
        if (w_fcollect && (w_fidx < 8'd32)) begin
          r_cstat_acc[w_fidx[4:0]] <= r_shift[26];
          if (w_fidx == 8'd31) begin
            r_cstat       <= {r_shift[26], r_cstat_acc[30:0]};
            r_cstat_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_cstat       = r_cstat;
  assign bus.o_cstat_valid = r_cstat_valid;
`else
  assign bus.o_cstat       = '0;
  assign bus.o_cstat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spdif_subframe_decoder.sv
// Directed bench for spdif_subframe_decoder: biphase line synthesised from 28-bit timeslot words.
// Pulse counters run at negedge; checks use immediate assertions.
module tb_spdif_subframe_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spdif_subframe_decoder_if bus ();

  spdif_subframe_decoder dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvalid = 0, nferr = 0, ncval = 0;
  int last_valid_cyc = 0, last_cval_cyc = 0;
  always @(negedge clk) begin
    if (bus.o_valid) begin
      nvalid++;
      last_valid_cyc = cyc;
    end
    if (bus.o_frame_err) nferr++;
    if (bus.o_cstat_valid) begin
      ncval++;
      last_cval_cyc = cyc;
    end
  end

  int npass = 0, nfail = 0, ntot = 0;
  int rise_cyc = 0;
  logic [23:0] mid_sample;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one sub-frame; enable is low from index 'drop', reset is pulsed at index 'rst_at'.
  task automatic subframe(input logic [2:0] flag, input logic [27:0] word, input logic pol,
                          input int drop, input int tail, input int rst_at);
    logic lvl;
    lvl = pol;
    for (int n = 0; n < 168; n++) begin
      @(posedge clk); #1;
      if (n == 0)   rise_cyc = cyc;
      if (n == 100) mid_sample = bus.o_sample;
      if (n % 6 == 0) lvl = ~lvl;
      if (n % 6 == 3 && word[n / 6]) lvl = ~lvl;
      bus.i_spdif  = lvl;
      bus.i_flag   = flag;
      bus.i_enable = (n < drop);
      rst          = (n == rst_at);
    end
    for (int t = 0; t < tail; t++) begin
      @(posedge clk); #1;
      bus.i_enable = 1'b1;
    end
    @(posedge clk); #1;
    bus.i_enable = 1'b0;
    rst          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int v0, f0;

  initial begin
    rst          = 1'b1;
    bus.i_spdif  = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_flag   = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fields", {bus.o_sample, bus.o_status, bus.o_channel, bus.o_block_start, bus.o_parity_err}, 32'h0);
    chk("reset_pulses", {bus.o_valid, bus.o_frame_err, bus.o_cstat_valid}, 32'h0);
    chk("reset_cstat", bus.o_cstat, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // X, normal polarity, 0x123456, C=1, P=0
    v0 = nvalid; f0 = nferr;
    subframe(3'b001, 28'h4123456, 1'b0, 168, 0, -1);
    chk("x_valid_count", nvalid - v0, 1);
    chk("x_latency", last_valid_cyc - rise_cyc, 168);
    chk("x_sample", bus.o_sample, 24'h123456);
    chk("x_chan_blk", {bus.o_channel, bus.o_block_start}, 2'b00);
    chk("x_status", bus.o_status, 3'b001);
    chk("x_parity", bus.o_parity_err, 1'b0);
    chk("x_no_ferr", nferr - f0, 0);

    // Y, inverted line (flag 101), 0xFFFFFF, P flipped; enable overlaps one cycle past index 167
    v0 = nvalid; f0 = nferr;
    subframe(3'b101, 28'h8FFFFFF, 1'b1, 168, 1, -1);
    chk("y_valid_count", nvalid - v0, 1);
    chk("y_latency", last_valid_cyc - rise_cyc, 168);
    chk("y_sample", bus.o_sample, 24'hFFFFFF);
    chk("y_channel", bus.o_channel, 1'b1);
    chk("y_parity", bus.o_parity_err, 1'b1);
    chk("y_overlap_no_ferr", nferr - f0, 0);

    // Z, 0x800000, P=1; previous word must hold mid-sub-frame
    v0 = nvalid;
    subframe(3'b100, 28'h8800000, 1'b0, 168, 0, -1);
    chk("z_held_before", mid_sample, 24'hFFFFFF);
    chk("z_valid_count", nvalid - v0, 1);
    chk("z_sample", bus.o_sample, 24'h800000);
    chk("z_chan_blk", {bus.o_channel, bus.o_block_start}, 2'b01);
    chk("z_parity", bus.o_parity_err, 1'b0);

    // enable dropped at index 100
    v0 = nvalid; f0 = nferr;
    subframe(3'b001, 28'h4123456, 1'b0, 100, 0, -1);
    chk("drop_ferr", nferr - f0, 1);
    chk("drop_no_valid", nvalid - v0, 0);
    chk("drop_held", bus.o_sample, 24'h800000);
    chk("drop_blk_held", bus.o_block_start, 1'b1);

    // recovery: X inverted (flag 110), 0x00A5C3, V=1 U=1
    v0 = nvalid;
    subframe(3'b110, 28'h300A5C3, 1'b1, 168, 0, -1);
    chk("rec_valid_count", nvalid - v0, 1);
    chk("rec_sample", bus.o_sample, 24'h00A5C3);
    chk("rec_status", bus.o_status, 3'b110);
    chk("rec_chan_blk_par", {bus.o_channel, bus.o_block_start, bus.o_parity_err}, 3'b000);

    // illegal flag 000: ignored completely
    v0 = nvalid; f0 = nferr;
    subframe(3'b000, 28'h4123456, 1'b0, 168, 0, -1);
    chk("ill_no_valid", nvalid - v0, 0);
    chk("ill_no_ferr", nferr - f0, 0);
    chk("ill_held", bus.o_sample, 24'h00A5C3);

    // reset at index 50, enable kept high afterwards
    v0 = nvalid; f0 = nferr;
    subframe(3'b001, 28'h4123456, 1'b0, 168, 0, 50);
    chk("rst_fields", {bus.o_sample, bus.o_status, bus.o_channel, bus.o_block_start, bus.o_parity_err}, 32'h0);
    chk("rst_no_pulse", (nvalid - v0) + (nferr - f0), 0);

`ifdef SPDIF_CSTAT_EN
    begin
      logic [31:0] cbits;
      logic [27:0] w;
      int lv;
      cbits = 32'hA5000102;
      ncval = 0;
      for (int f = 0; f < 32; f++) begin
        w = {cbits[f], cbits[f], 26'h0};
        subframe((f == 0) ? 3'b100 : 3'b001, w, 1'b0, 168, 0, -1);
        if (f == 31) lv = last_valid_cyc;
        subframe(3'b010, 28'h0, 1'b0, 168, 0, -1);
      end
      chk("cstat_valid_count", ncval, 1);
      chk("cstat_word", bus.o_cstat, 32'hA5000102);
      chk("cstat_coincident", last_cval_cyc, lv);
    end
`else
    chk("cstat_tied", bus.o_cstat, 32'h0);
    chk("cstat_valid_tied", ncval, 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/spdif_subframe_decoder.md
# spdif_subframe_decoder

Downstream stage of the S/PDIF preamble detector. Consumes the oversampled S/PDIF line together with the detector's enable/flag pair. Decodes the 28 biphase-mark data timeslots of each sub-frame into:
- a 24-bit audio word,
- the V/U/C status bits,
- a parity check.

Results are presented as a single-cycle valid pulse to the sample FIFO and EQ path.

## Interface
Parameters:
- SPS, 6, line samples per timeslot (two biphase cells of 3 samples); mid-cell sample points are 1 and 4.
- SLOTS, 28, data timeslots per sub-frame (timeslots 4..31).

Ports:
- clk  input  1  system clock, same clock as the preamble detector.
- i_rst  input  1  synchronous, active-high reset.
- i_spdif  input  1  oversampled S/PDIF line, one sample per clk.
- i_enable  input  1  high for the data portion of a sub-frame, from the detector.
- i_flag  input  3  preamble code, valid while i_enable is high.
- o_valid  output  1  one-cycle pulse: sub-frame decoded.
- o_sample  output  24  audio word, timeslots 4..27, LSB first on the line.
- o_channel  output  1  0 = left (X or Z), 1 = right (Y).
- o_block_start  output  1  sub-frame carried a Z preamble.
- o_status  output  3  {V, U, C}.
- o_parity_err  output  1  parity over timeslots 4..31 is odd.
- o_frame_err  output  1  one-cycle pulse: i_enable dropped before all 168 samples were taken.
- o_cstat  output  32  first 32 channel-status bits of the block (SPDIF_CSTAT_EN only).
- o_cstat_valid  output  1  one-cycle pulse: o_cstat updated (SPDIF_CSTAT_EN only).

## Operation
States:
- IDLE → RUN: on the first cycle with i_enable=1 and a legal i_flag.
- RUN → DONE: when sample index 167 is taken.
- RUN → IDLE: if i_enable=0 before index 167; pulse o_frame_err.
- DONE → IDLE: after one cycle; o_valid pulses in DONE.

Flag decode:
- 001 or 110 → X; 010 or 101 → Y; 100 or 011 → Z.
- One set bit means normal polarity, two set bits means inverted line polarity. Biphase decoding is polarity-independent.
- Flags 000 and 111 are illegal: stay in IDLE, ignore the sub-frame, no output, no error.
- The flag is latched on the IDLE→RUN cycle.

Sampling:
- The IDLE→RUN cycle takes sample index 0. A 8-bit index n runs 0..167 and advances every cycle while i_enable=1.
- Slot k = n/6, phase p = n%6. Store s1 at p=1; at p=4 the bit is b[k] = s1 XOR i_spdif (a mid-slot transition means 1).
- Bits are shifted into a 28-bit register LSB first.

Field mapping:
- b[0..23] → o_sample[0..23].
- b[24] = V, b[25] = U, b[26] = C.
- b[27] = P. o_parity_err = XOR of b[0..27].

Output registers:
- o_sample, o_channel, o_block_start, o_status and o_parity_err load in the DONE cycle and hold until the next DONE.
- o_valid and o_frame_err are pulses only.

Reset:
- All outputs go to 0, state to IDLE, index to 0, frame counter to 0.
- Reset mid-sub-frame discards the partial word; no pulse is produced.

## Timing
- o_valid is high in the cycle after the clock edge that takes sample 167, i.e. 168 cycles after the IDLE→RUN cycle.
- Decoded fields are stable in that same cycle.
- If i_enable is low at sample index n<168, o_frame_err pulses in the following cycle.
- i_enable still high in the cycle after index 167 (detector hand-off overlap) is ignored. A new sub-frame is accepted only after i_enable has been seen low for at least one cycle.
- No backpressure: the consumer must accept o_valid unconditionally. Minimum spacing between o_valid pulses is 169 cycles.

## Configuration
SPDIF_CSTAT_EN.

With the macro defined:
- An 8-bit frame counter is reset to 0 on a Z left sub-frame and incremented on each decoded left sub-frame, saturating at 191.
- For frame counter values 0..31, the C bit of the left sub-frame is written to o_cstat[count].
- o_cstat_valid pulses together with the o_valid of frame 31.
- A frame error or missing Z restarts collection at the next Z.

Without the macro:
- o_cstat is tied to 0 and o_cstat_valid to 0.
- No counter or collection logic is present.

## Test plan
- X sub-frame, normal polarity, sample 0x123456, V=0 U=0 C=1, correct P → one o_valid 168 cycles after the enable rise; o_sample=0x123456, o_channel=0, o_block_start=0, o_status=3'b001, o_parity_err=0.
- Y sub-frame with inverted line and flag 101, sample 0xFFFFFF, P flipped → o_sample=0xFFFFFF, o_channel=1, o_parity_err=1.
- Z sub-frame, sample 0x800000 → o_block_start=1, o_channel=0; previous outputs held until this o_valid.
- i_enable dropped at index 100 → o_frame_err pulse next cycle, no o_valid, outputs unchanged; next legal sub-frame decodes normally.
- Flag 000 with i_enable high for 168 cycles → no o_valid, no o_frame_err. i_rst asserted at index 50 → all outputs 0, no pulse.
- SPDIF_CSTAT_EN: 32 stereo frames starting at Z, left C bits encoding 0xA5000102 → o_cstat=0xA5000102 with o_cstat_valid coincident with frame 31's left o_valid.
